// File: rtl/alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_serial_ctrl
//  Description : Bit-serial ALU sequencer. One 1-bit ALU slice is reused
//                once per cycle, LSB first, to produce a WIDTH-bit result
//                plus zero/carry/overflow flags. A start/busy/done handshake
//                frames each operation.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             cout_o,
    output logic             overflow_o
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    localparam logic [CW-1:0] C_LAST_BIT = CW'(WIDTH - 1);

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [3:0]       op_q, op_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             done_q, done_d;
    logic             zero_q, zero_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    // slice control and data
    logic       w_a_inv, w_b_inv;
    logic [1:0] w_slice_op;
    logic       w_sa, w_sb, w_less;
    logic       w_slice_res, w_slice_cout;
    logic       w_start_legal;
    logic       w_last;

    assign w_less = 1'b0;
    assign w_last = (cnt_q == C_LAST_BIT);

    // Decode which ctrl_i codes start a real RUN phase
    always_comb begin
        w_start_legal = 1'b0;
        case (ctrl_i)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR: w_start_legal = 1'b1;
            default:                                       w_start_legal = 1'b0;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state: illegal codes never leave IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i && w_start_legal) state_d = S_RUN;
            S_RUN:   if (w_last)                   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: slice controls derived from the latched op (SLT is a full subtract)
    always_comb begin
        w_a_inv    = 1'b0;
        w_b_inv    = 1'b0;
        w_slice_op = 2'b00;
        case (op_q)
            OP_AND: w_slice_op = 2'b00;
            OP_OR:  w_slice_op = 2'b01;
            OP_ADD: w_slice_op = 2'b10;
            OP_SUB, OP_SLT: begin
                w_b_inv    = 1'b1;
                w_slice_op = 2'b10;
            end
            OP_NOR: begin
                w_a_inv    = 1'b1;
                w_b_inv    = 1'b1;
                w_slice_op = 2'b00;
            end
            default: w_slice_op = 2'b00;
        endcase
    end

    // 1-bit ALU slice operating on the current bit position
    always_comb begin
        w_sa         = a_q[cnt_q] ^ w_a_inv;
        w_sb         = b_q[cnt_q] ^ w_b_inv;
        w_slice_cout = (w_sa & w_sb) | (w_sa & carry_q) | (w_sb & carry_q);
        case (w_slice_op)
            2'b00:   w_slice_res = w_sa & w_sb;
            2'b01:   w_slice_res = w_sa | w_sb;
            2'b10:   w_slice_res = w_sa ^ w_sb ^ carry_q;
            default: w_slice_res = w_less;
        endcase
    end

    // Datapath next-state: operand latch, per-bit result/carry, final flags
    always_comb begin
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        carry_d = carry_q;
        res_d   = res_q;
        done_d  = 1'b0;
        zero_d  = zero_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (state_q == S_IDLE) begin
            if (start_i) begin
                a_d     = src1_i;
                b_d     = src2_i;
                op_d    = ctrl_i;
                cnt_d   = '0;
                carry_d = (ctrl_i == OP_SUB) || (ctrl_i == OP_SLT);
                res_d   = '0;
                zero_d  = 1'b1;
                cout_d  = 1'b0;
                ovf_d   = 1'b0;
                // an illegal code completes immediately with a zero result
                done_d  = !w_start_legal;
            end
        end else begin
            res_d[cnt_q] = w_slice_res;
            carry_d      = w_slice_cout;
            cnt_d        = cnt_q + 1'b1;
            if (w_last) begin
                cnt_d  = '0;
                done_d = 1'b1;
                // carry_q here is the carry into the MSB
                cout_d = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_SLT) ? w_slice_cout : 1'b0;
                ovf_d  = (op_q == OP_ADD) || (op_q == OP_SUB) ? (carry_q ^ w_slice_cout) : 1'b0;
                if (op_q == OP_SLT)
                    res_d = {{(WIDTH-1){1'b0}}, w_slice_res ^ (carry_q ^ w_slice_cout)};
                zero_d = (res_d == '0);
            end
        end
    end

    // Datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            done_q  <= 1'b0;
            zero_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            done_q  <= done_d;
            zero_q  <= zero_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign busy_o     = (state_q == S_RUN);
    assign done_o     = done_q;
    assign result_o   = res_q;
    assign zero_o     = zero_q;
    assign cout_o     = cout_q;
    assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_serial_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_serial_ctrl
//  Description : Directed self-checking bench for alu_serial_ctrl (WIDTH=32).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_serial_ctrl;

    localparam int WIDTH = 32;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             start_i = 1'b0;
    logic [WIDTH-1:0] src1_i = '0;
    logic [WIDTH-1:0] src2_i = '0;
    logic [3:0]       ctrl_i = '0;
    logic             busy_o, done_o, zero_o, cout_o, overflow_o;
    logic [WIDTH-1:0] result_o;

    int checks = 0;
    int errors = 0;
    int lat;
    int bcnt;
    bit seen_done;

    alu_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .start_i    (start_i),
        .src1_i     (src1_i),
        .src2_i     (src2_i),
        .ctrl_i     (ctrl_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .cout_o     (cout_o),
        .overflow_o (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drive an op; returns #1 after the accepting edge with start_i dropped
    task automatic start_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        ctrl_i  = c;
        src1_i  = a;
        src2_i  = b;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
    endtask

    // count edges until done_o is seen (0 = already in done cycle), and busy samples before it
    task automatic wait_done(output int n, output int busy_cnt);
        n = 0;
        busy_cnt = 0;
        while (!done_o && n < 40) begin
            if (busy_o) busy_cnt++;
            @(posedge clk_i);
            #1;
            n++;
        end
        if (!done_o) chk("timeout", 32'(n), 32'd32);
    endtask

    task automatic chk_flags(input string tag, input logic [31:0] r, input logic z, input logic c, input logic v);
        chk({tag, "_result"}, result_o, r);
        chk({tag, "_zero"}, 32'(zero_o), 32'(z));
        chk({tag, "_cout"}, 32'(cout_o), 32'(c));
        chk({tag, "_ovf"}, 32'(overflow_o), 32'(v));
    endtask

    initial begin
        // reset state
        #2;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_done", 32'(done_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_zero", 32'(zero_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;

        // ADD 7+5 with latency and busy duration
        start_op(4'b0010, 32'h7, 32'h5);
        chk("add_busy_start", 32'(busy_o), 32'd1);
        wait_done(lat, bcnt);
        chk("add_latency", 32'(lat), 32'd32);
        chk("add_busy_cycles", 32'(bcnt), 32'd32);
        chk("add_busy_done", 32'(busy_o), 32'd0);
        chk_flags("add", 32'h0000000C, 1'b0, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
        chk("add_done_pulse", 32'(done_o), 32'd0);
        chk("add_hold", result_o, 32'h0000000C);

        start_op(4'b0010, 32'hFFFFFFFF, 32'h1);
        wait_done(lat, bcnt);
        chk_flags("add_wrap", 32'h0, 1'b1, 1'b1, 1'b0);

        start_op(4'b0110, 32'h80000000, 32'h1);
        wait_done(lat, bcnt);
        chk_flags("sub_ovf", 32'h7FFFFFFF, 1'b0, 1'b1, 1'b1);

        start_op(4'b0111, 32'hFFFFFFFF, 32'h1);
        wait_done(lat, bcnt);
        chk_flags("slt_neg", 32'h1, 1'b0, 1'b1, 1'b0);

        start_op(4'b0111, 32'h7FFFFFFF, 32'h80000000);
        wait_done(lat, bcnt);
        chk_flags("slt_big", 32'h0, 1'b1, 1'b0, 1'b0);

        start_op(4'b1100, 32'h0, 32'h0);
        wait_done(lat, bcnt);
        chk_flags("nor", 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

        start_op(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00);
        wait_done(lat, bcnt);
        chk_flags("and", 32'hF000F000, 1'b0, 1'b0, 1'b0);

        start_op(4'b0001, 32'hF0F0F0F0, 32'hFF00FF00);
        wait_done(lat, bcnt);
        chk_flags("or", 32'hFFF0FFF0, 1'b0, 1'b0, 1'b0);

        // start mid-RUN with different operands is ignored
        start_op(4'b0010, 32'h100, 32'h23);
        repeat (5) @(posedge clk_i);
        #1;
        start_op(4'b0000, 32'hDEADBEEF, 32'h12345678);
        wait_done(lat, bcnt);
        chk("ignore_latency", 32'(lat), 32'd26);
        chk_flags("ignore", 32'h00000123, 1'b0, 1'b0, 1'b0);

        // back-to-back start in the done cycle
        start_op(4'b0110, 32'h10, 32'h3);
        chk("b2b_busy", 32'(busy_o), 32'd1);
        wait_done(lat, bcnt);
        chk("b2b_latency", 32'(lat), 32'd32);
        chk_flags("b2b", 32'h0000000D, 1'b0, 1'b1, 1'b0);

        // reset pulse at RUN bit 10 aborts without done
        start_op(4'b0010, 32'h55, 32'h66);
        repeat (10) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        #1;
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_done", 32'(done_o), 32'd0);
        chk_flags("arst", 32'h0, 1'b0, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk_i);
            #1;
            if (done_o || busy_o) seen_done = 1'b1;
        end
        chk("arst_no_done", 32'(seen_done), 32'd0);

        // illegal ctrl completes after one edge with zero result
        start_op(4'b1111, 32'h1234, 32'h5678);
        chk("ill_done", 32'(done_o), 32'd1);
        chk("ill_busy", 32'(busy_o), 32'd0);
        chk_flags("ill", 32'h0, 1'b1, 1'b0, 1'b0);
        @(posedge clk_i);
        #1;
        chk("ill_done_pulse", 32'(done_o), 32'd0);
        chk("ill_stay_idle", 32'(busy_o), 32'd0);

        // normal op after illegal one still works
        start_op(4'b0010, 32'h7FFFFFFF, 32'h1);
        wait_done(lat, bcnt);
        chk_flags("add_povf", 32'h80000000, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
